// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared FSM state encoding and SPI command codes for the slave controller
package spi_slave_pkg;
  typedef enum logic [2:0] {IDLE, CMD, RX, WAIT_TX, TX, DONE} state_e;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: loads a read word and serialises it onto MISO, one bit per cycle with a valid flag
module spi_tx_shifter #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_miso,
  output logic              o_valid,
  output logic              o_last
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [DATA_W-1:0] r_sh;
  logic [CW-1:0]     r_cnt;
  logic              r_miso;
  logic              r_valid;
  logic              w_head_in;
  logic              w_head_sh;
  logic [DATA_W-1:0] w_adv_in;
  logic [DATA_W-1:0] w_adv_sh;
  assign w_head_in = MSB_FIRST ? i_data[DATA_W-1] : i_data[0];
  assign w_head_sh = MSB_FIRST ? r_sh[DATA_W-1] : r_sh[0];
  assign w_adv_in  = MSB_FIRST ? i_data << 1 : i_data >> 1;
  assign w_adv_sh  = MSB_FIRST ? r_sh << 1 : r_sh >> 1;
  // the first bit goes straight onto MISO at load so it is valid in the first TX cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_miso  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_miso  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_miso  <= w_head_in;
      r_sh    <= w_adv_in;
      r_cnt   <= CW'(DATA_W - 1);
      r_valid <= 1'b1;
    end else if (i_shift && r_valid) begin
      if (r_cnt == '0) begin
        r_miso  <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_miso <= w_head_sh;
        r_sh   <= w_adv_sh;
        r_cnt  <= r_cnt - CW'(1);
      end
    end
  end
  assign o_miso  = r_miso;
  assign o_valid = r_valid;
  assign o_last  = r_valid && (r_cnt == '0);
endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave frame controller; deserialises cmd+payload frames, checks read sequencing,
// waits (bounded) for memory read data and serialises it back on MISO.
module spi_slave_ctrl
  import spi_slave_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic              valid_MISO,
  output logic              sready,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  state_e            r_state;
  state_e            w_next;
  logic [1:0]        r_cmd;
  logic [DATA_W-1:0] r_pay;
  logic [BW-1:0]     r_bit_cnt;
  logic [TW-1:0]     r_to_cnt;
  logic              r_rd_pend;
  logic [DATA_W+1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_frame_err;
  logic              w_abort;
  logic              w_rx_last;
  logic              w_rd_err;
  logic              w_tx_load;
  logic              w_tx_last;
  logic              w_timeout;
  logic [DATA_W-1:0] w_pay_next;
  assign w_pay_next = MSB_FIRST ? {r_pay[DATA_W-2:0], MOSI} : {MOSI, r_pay[DATA_W-1:1]};
  assign w_rd_err   = w_rx_last && (r_cmd == CMD_RD_DATA) && !r_rd_pend;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next    = r_state;
    w_abort   = 1'b0;
    w_rx_last = 1'b0;
    w_tx_load = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: w_next = ss_n ? IDLE : CMD;
      CMD: begin
        w_abort = ss_n;
        w_next  = ss_n ? IDLE : RX;
      end
      RX:
        if (ss_n) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (r_bit_cnt == BW'(DATA_W - 1)) begin
          w_rx_last = 1'b1;
          w_next    = (r_cmd == CMD_RD_DATA && r_rd_pend) ? WAIT_TX : DONE;
        end
      WAIT_TX:
        if (ss_n) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (tx_valid) begin
          w_tx_load = 1'b1;
          w_next    = TX;
        end else if (r_to_cnt >= TW'(TX_TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      TX:
        if (ss_n) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (w_tx_last) begin
          w_next = DONE;
        end
      DONE: w_next = ss_n ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // a read-data frame without a preceding read-address frame is rejected instead of delivered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= '0;
      r_pay       <= '0;
      r_bit_cnt   <= '0;
      r_to_cnt    <= '0;
      r_rd_pend   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= w_rx_last && !w_rd_err;
      r_frame_err <= w_abort || w_rd_err || w_timeout;
      if (r_state == IDLE && !ss_n) r_cmd <= {MOSI, 1'b0};
      if (r_state == CMD && !ss_n) begin
        r_cmd[0]  <= MOSI;
        r_bit_cnt <= '0;
      end
      if (r_state == RX && !ss_n) begin
        r_pay     <= w_pay_next;
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
      if (w_rx_last && !w_rd_err) r_rx_data <= {r_cmd, w_pay_next};
      if (w_rx_last && r_cmd == CMD_RD_ADDR) r_rd_pend <= 1'b1;
      else if (w_rx_last && r_cmd == CMD_RD_DATA) r_rd_pend <= 1'b0;
      r_to_cnt <= (r_state != WAIT_TX) ? '0 :
                  (r_to_cnt == TW'(TX_TIMEOUT)) ? r_to_cnt : r_to_cnt + TW'(1);
    end
  end
  spi_tx_shifter #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tx_load),
    .i_shift(r_state == TX && !ss_n),
    .i_clear(w_abort),
    .i_data (tx_data),
    .o_miso (MISO),
    .o_valid(valid_MISO),
    .o_last (w_tx_last)
  );
  assign sready    = (r_state == IDLE);
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
endmodule
